bsg_clk_gen_pearl_monitor_meter: RTL and testbench

- Downstream consumer of the clock-generator monitor output, i.e. the divided-down clock observed on clk_monitor.
- Runs entirely in a trusted reference clock domain and treats the monitor clock as an asynchronous data input.
- Counts reference cycles across a fixed window of monitor rising edges and presents the result through a valid/ready handshake.
- Flags timeout when the monitor clock is dead and overflow when the count saturates.

---
 rtl/bsg_clk_gen_pearl_monitor_meter.sv | 130 +++++++++++++
 tb/tb_bsg_clk_gen_pearl_monitor_meter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_clk_gen_pearl_monitor_meter.sv
// bsg_clk_gen_pearl_monitor_meter: measures reference cycles per window of clk_monitor_i periods
// Ports: clk_i reference clock; reset_n_i async active-low reset; clk_monitor_i async monitor clock (data only);
//   en_i measurement enable; v_o/ready_i result handshake; count_o cycle count; overflow_o saturation flag;
//   timeout_o dead-monitor flag. Optional macro BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN re-arms after each result.
module bsg_clk_gen_pearl_monitor_meter #(
  parameter int sync_stages_p  = 2,
  parameter int window_edges_p = 16,
  parameter int count_width_p  = 24,
  parameter int timeout_p      = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clk_monitor_i,
  input  logic                     en_i,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [count_width_p-1:0] count_o,
  output logic                     overflow_o,
  output logic                     timeout_o
);
  localparam int tw = $clog2(timeout_p + 1);
  localparam int ew = $clog2(window_edges_p + 1);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;
  state_e                   state;
  logic [sync_stages_p-1:0] sync;
  logic                     hist, ovf, rise, go, last, tmo;
  logic [count_width_p-1:0] cyc;
  logic [ew-1:0]            edges;
  logic [tw-1:0]            tcnt;
`ifdef BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN
  localparam bit cont_lp = 1'b1;
  assign go = en_i;
`else
  localparam bit cont_lp = 1'b0;
  logic en_q;
  // one measurement per en_i assertion: leave IDLE only on its rising edge
  assign go = en_i & ~en_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) en_q <= 1'b0;
    else en_q <= en_i;
`endif
  assign rise = sync[sync_stages_p-1] & ~hist;
  assign tmo  = tcnt == tw'(timeout_p - 1);
  assign last = edges == ew'(window_edges_p - 1);
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      sync       <= '0;
      hist       <= 1'b0;
      v_o        <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
      cyc        <= '0;
      edges      <= '0;
      tcnt       <= '0;
      ovf        <= 1'b0;
    end else begin
      sync <= {sync[sync_stages_p-2:0], clk_monitor_i};
      hist <= sync[sync_stages_p-1];
      case (state)
        IDLE: begin
          cyc   <= '0;
          edges <= '0;
          tcnt  <= '0;
          ovf   <= 1'b0;
          if (go) state <= ARM;
        end
        ARM: begin
          if (!en_i) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (rise) begin
            cyc   <= '0;
            edges <= '0;
            tcnt  <= '0;
            ovf   <= 1'b0;
            state <= MEASURE;
          end else if (tmo) begin
            state      <= DONE;
            v_o        <= 1'b1;
            timeout_o  <= 1'b1;
            count_o    <= '0;
            overflow_o <= 1'b0;
            tcnt       <= '0;
          end else tcnt <= tcnt + 1'b1;
        end
        MEASURE: begin
          if (!en_i) begin
            state <= IDLE;
            cyc   <= '0;
            edges <= '0;
            tcnt  <= '0;
            ovf   <= 1'b0;
          end else begin
            cyc <= &cyc ? cyc : cyc + 1'b1;
            ovf <= ovf | &cyc;
            // a rise outranks a simultaneous timeout
            if (rise) begin
              tcnt  <= '0;
              edges <= edges + 1'b1;
              if (last) begin
                state      <= DONE;
                v_o        <= 1'b1;
                count_o    <= &cyc ? cyc : cyc + 1'b1;
                overflow_o <= ovf | &cyc;
                timeout_o  <= 1'b0;
              end
            end else if (tmo) begin
              state      <= DONE;
              v_o        <= 1'b1;
              timeout_o  <= 1'b1;
              count_o    <= '0;
              overflow_o <= 1'b0;
              tcnt       <= '0;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            v_o       <= 1'b0;
            timeout_o <= 1'b0;
            state     <= (cont_lp && en_i) ? ARM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_clk_gen_pearl_monitor_meter.sv
// tb_bsg_clk_gen_pearl_monitor_meter: directed bench for the monitor meter (24-bit and 8-bit count instances)
module tb_bsg_clk_gen_pearl_monitor_meter;
  logic        clk = 0, reset_n = 0, mon = 0, en = 0, ready = 1;
  logic        v, ovf, to, v8, ovf8, to8;
  logic [23:0] cnt;
  logic [7:0]  cnt8;
  int          pass = 0, total = 0, k;
  bit          mon_run = 0, jit = 0, alt = 0;

  always #5 clk = ~clk;

  bsg_clk_gen_pearl_monitor_meter dut (
    .clk_i(clk), .reset_n_i(reset_n), .clk_monitor_i(mon), .en_i(en), .v_o(v),
    .ready_i(ready), .count_o(cnt), .overflow_o(ovf), .timeout_o(to));

  bsg_clk_gen_pearl_monitor_meter #(.count_width_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .clk_monitor_i(mon), .en_i(en), .v_o(v8),
    .ready_i(ready), .count_o(cnt8), .overflow_o(ovf8), .timeout_o(to8));

  // monitor: period 30, or alternating 29/31 when jit is set
  initial forever begin
    if (mon_run) begin
      mon = 1;
      repeat (15) @(negedge clk);
      mon = 0;
      repeat (jit ? (alt ? 16 : 14) : 15) @(negedge clk);
      alt = ~alt;
    end else begin
      mon = 0;
      @(negedge clk);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task wait_v(input int budget);
    k = 0;
    while (v !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++; if ({v, cnt, ovf, to} !== 27'd0) $display("FAIL reset_out: got %0h want 0", {v, cnt, ovf, to}); else pass++;
    total++; if ({v8, cnt8, ovf8, to8} !== 11'd0) $display("FAIL reset_out8: got %0h want 0", {v8, cnt8, ovf8, to8}); else pass++;
    reset_n = 1;
    @(negedge clk);
  endtask

  task test_steady;
    jit = 0; mon_run = 1;
    repeat (100) @(negedge clk);
    en = 1;
    wait_v(2000);
    total++; if (v !== 1'b1) $display("FAIL steady_v: got %b want 1", v); else pass++;
    total++; if (cnt !== 24'd480) $display("FAIL steady_count: got %0d want 480", cnt); else pass++;
    total++; if ({ovf, to} !== 2'b00) $display("FAIL steady_flags: got %b want 00", {ovf, to}); else pass++;
    en = 0;
    @(negedge clk);
    total++; if (v !== 1'b0) $display("FAIL steady_v_one_cycle: got %b want 0", v); else pass++;
  endtask

  task test_overflow;
    en = 1;
    wait_v(2000);
    total++; if (v8 !== 1'b1) $display("FAIL ovf_v: got %b want 1", v8); else pass++;
    total++; if (cnt8 !== 8'd255) $display("FAIL ovf_count: got %0d want 255", cnt8); else pass++;
    total++; if ({ovf8, to8} !== 2'b10) $display("FAIL ovf_flags: got %b want 10", {ovf8, to8}); else pass++;
    en = 0;
    @(negedge clk);
  endtask

  task test_jitter;
    jit = 1;
    repeat (100) @(negedge clk);
    en = 1;
    wait_v(2000);
    total++; if (v !== 1'b1) $display("FAIL jitter_v: got %b want 1", v); else pass++;
    total++; if (cnt !== 24'd480) $display("FAIL jitter_count: got %0d want 480", cnt); else pass++;
    en = 0;
    @(negedge clk);
    jit = 0;
  endtask

  task test_timeout;
    mon_run = 0;
    repeat (60) @(negedge clk);
    en = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (v !== 1'b1 && k < 5000);
    total++; if (k !== 4097) $display("FAIL timeout_latency: got %0d want 4097", k); else pass++;
    total++; if (to !== 1'b1) $display("FAIL timeout_flag: got %b want 1", to); else pass++;
    total++; if ({cnt, ovf} !== 25'd0) $display("FAIL timeout_count: got %0d/%b want 0/0", cnt, ovf); else pass++;
    en = 0;
    @(negedge clk);
    total++; if ({v, to} !== 2'b00) $display("FAIL timeout_clear: got %b want 00", {v, to}); else pass++;
  endtask

  task test_backpressure;
    mon_run = 1;
    repeat (60) @(negedge clk);
    ready = 0; en = 1;
    wait_v(2000);
    total++; if (cnt !== 24'd480) $display("FAIL bp_count: got %0d want 480", cnt); else pass++;
    repeat (50) begin
      @(negedge clk);
      total++; if ({v, cnt} !== {1'b1, 24'd480}) $display("FAIL bp_hold: got v=%b cnt=%0d want v=1 cnt=480", v, cnt); else pass++;
    end
    ready = 1; en = 0;
    @(negedge clk);
    total++; if (v !== 1'b0) $display("FAIL bp_release: got %b want 0", v); else pass++;
  endtask

  task test_abort;
    bit seen;
    en = 1;
    repeat (210) @(negedge clk);
    en = 0;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (v === 1'b1) seen = 1;
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_no_v: got %b want 0", seen); else pass++;
    en = 1;
    wait_v(2000);
    total++; if ({v, cnt} !== {1'b1, 24'd480}) $display("FAIL abort_remeasure: got v=%b cnt=%0d want v=1 cnt=480", v, cnt); else pass++;
    en = 0;
    @(negedge clk);
  endtask

  task test_reset_mid;
    en = 1;
    repeat (200) @(negedge clk);
    total++; if (cnt !== 24'd480) $display("FAIL mid_precount: got %0d want 480", cnt); else pass++;
    reset_n = 0;
    #1;
    total++; if ({v, cnt, ovf, to} !== 27'd0) $display("FAIL mid_reset_out: got %0h want 0", {v, cnt, ovf, to}); else pass++;
    @(negedge clk);
    reset_n = 1; en = 0;
    @(negedge clk);
    en = 1;
    wait_v(2000);
    total++; if ({v, cnt} !== {1'b1, 24'd480}) $display("FAIL mid_fresh: got v=%b cnt=%0d want v=1 cnt=480", v, cnt); else pass++;
    en = 0;
    @(negedge clk);
  endtask

`ifdef BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN
  task test_continuous;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_v(2000);
      total++; if ({v, cnt} !== {1'b1, 24'd480}) $display("FAIL cont_%0d: got v=%b cnt=%0d want v=1 cnt=480", i, v, cnt); else pass++;
      @(negedge clk);
    end
    en = 0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_steady;
    test_overflow;
    test_jitter;
    test_timeout;
    test_backpressure;
    test_abort;
    test_reset_mid;
`ifdef BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN
    test_continuous;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
